// File: rtl/ps2_kbd_fifo_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// special scan codes and the frame validity check.
package ps2_kbd_fifo_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CAPS   = 8'h58;
    localparam logic [7:0] ASCII_NONE = 8'h00;

    // A frame is good when data+parity hold an odd number of ones and stop=1.
    function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                      input logic stop);
        return (^{data, parity}) & stop;
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo_rx_if.sv
// Bus between the PS/2 receiver and its surroundings: raw PS/2 lines,
// FIFO read strobe, and the character/status outputs.
interface ps2_kbd_fifo_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ps2d;
    logic          ps2c;
    logic          rd_en;
    logic [7:0]    ascii;
    logic          valid;
    logic [CW-1:0] count;
    logic          overflow;
    logic          frame_err;
    logic          shift_held;
    logic          caps_lock;

    // System / keyboard side: drives the lines and the read strobe.
    modport master (
        output ps2d, ps2c, rd_en,
        input  ascii, valid, count, overflow, frame_err, shift_held, caps_lock
    );

    // Receiver side.
    modport slave (
        input  ps2d, ps2c, rd_en,
        output ascii, valid, count, overflow, frame_err, shift_held, caps_lock
    );
endinterface

// File: rtl/ps2_kbd_fifo_rx_key2ascii.sv
// Scan-code set 2 to ASCII translation for the main alphanumeric block.
// Letters honour i_upper; digits and symbols pick their shifted glyph on
// i_shifted. Unmapped codes give ASCII_NONE.
module ps2_key2ascii
    import ps2_kbd_fifo_rx_pkg::*;
(
    input  logic [7:0] i_scan_code,
    input  logic       i_upper,
    input  logic       i_shifted,
    output logic [7:0] o_ascii
);

    logic [7:0] w_base;
    logic [7:0] w_alt;
    logic       w_letter;

    // Table lookup: base glyph and shifted glyph for each code.
    always_comb begin
        w_base = ASCII_NONE;
        w_alt  = ASCII_NONE;
        case (i_scan_code)
            8'h1C: w_base = "a";   8'h32: w_base = "b";   8'h21: w_base = "c";
            8'h23: w_base = "d";   8'h24: w_base = "e";   8'h2B: w_base = "f";
            8'h34: w_base = "g";   8'h33: w_base = "h";   8'h43: w_base = "i";
            8'h3B: w_base = "j";   8'h42: w_base = "k";   8'h4B: w_base = "l";
            8'h3A: w_base = "m";   8'h31: w_base = "n";   8'h44: w_base = "o";
            8'h4D: w_base = "p";   8'h15: w_base = "q";   8'h2D: w_base = "r";
            8'h1B: w_base = "s";   8'h2C: w_base = "t";   8'h3C: w_base = "u";
            8'h2A: w_base = "v";   8'h1D: w_base = "w";   8'h22: w_base = "x";
            8'h35: w_base = "y";   8'h1A: w_base = "z";
            8'h45: {w_base, w_alt} = "0)";
            8'h16: {w_base, w_alt} = "1!";
            8'h1E: {w_base, w_alt} = "2@";
            8'h26: {w_base, w_alt} = "3#";
            8'h25: {w_base, w_alt} = "4$";
            8'h2E: {w_base, w_alt} = "5%";
            8'h36: {w_base, w_alt} = "6^";
            8'h3D: {w_base, w_alt} = "7&";
            8'h3E: {w_base, w_alt} = "8*";
            8'h46: {w_base, w_alt} = "9(";
            8'h0E: {w_base, w_alt} = "`~";
            8'h4E: {w_base, w_alt} = "-_";
            8'h55: {w_base, w_alt} = "=+";
            8'h54: {w_base, w_alt} = "[{";
            8'h5B: {w_base, w_alt} = "]}";
            8'h5D: {w_base, w_alt} = {8'h5C, 8'h7C};
            8'h4C: {w_base, w_alt} = ";:";
            8'h52: {w_base, w_alt} = {8'h27, 8'h22};
            8'h41: {w_base, w_alt} = ",<";
            8'h49: {w_base, w_alt} = ".>";
            8'h4A: {w_base, w_alt} = "/?";
            8'h29: {w_base, w_alt} = {8'h20, 8'h20};
            8'h5A: {w_base, w_alt} = {8'h0D, 8'h0D};
            8'h66: {w_base, w_alt} = {8'h08, 8'h08};
            8'h0D: {w_base, w_alt} = {8'h09, 8'h09};
            8'h76: {w_base, w_alt} = {8'h1B, 8'h1B};
            default: ;
        endcase
    end

    // Case selection: letters shift by 0x20, everything else picks a column.
    always_comb begin
        w_letter = (w_base >= 8'h61) && (w_base <= 8'h7A);
        if (w_letter)
            o_ascii = i_upper ? (w_base - 8'h20) : w_base;
        else
            o_ascii = i_shifted ? w_alt : w_base;
    end

endmodule

// File: rtl/ps2_kbd_fifo_rx.sv
// PS/2 keyboard receiver: synchronise and deglitch the lines, capture
// 11-bit frames, decode make/break/extended prefixes and modifiers, and
// queue translated characters in a first-word-fall-through FIFO.
module ps2_kbd_fifo_rx
    import ps2_kbd_fifo_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              i_sysclk,
    input  logic              i_reset_n,
    ps2_kbd_fifo_rx_if.slave  io_bus
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    // Line synchroniser and ps2c filter
    logic           r_ps2c_meta, r_ps2c_sync, r_ps2d_meta, r_ps2d_sync;
    logic [FCW-1:0] r_filt_cnt;
    logic           r_filt, r_filt_prev;
    logic           w_fall;

    // Two-flop synchronisers on both asynchronous lines.
    always_ff @(posedge i_sysclk) begin
        if (!i_reset_n) begin
            r_ps2c_meta <= 1'b0;
            r_ps2c_sync <= 1'b0;
            r_ps2d_meta <= 1'b0;
            r_ps2d_sync <= 1'b0;
        end else begin
            r_ps2c_meta <= io_bus.ps2c;
            r_ps2c_sync <= r_ps2c_meta;
            r_ps2d_meta <= io_bus.ps2d;
            r_ps2d_sync <= r_ps2d_meta;
        end
    end

    // Filtered ps2c follows the line only after FILTER_LEN agreeing samples.
    always_ff @(posedge i_sysclk) begin
        if (!i_reset_n) begin
            r_filt_cnt  <= '0;
            r_filt      <= 1'b0;
            r_filt_prev <= 1'b0;
        end else begin
            r_filt_prev <= r_filt;
            if (r_ps2c_sync == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
                r_filt     <= r_ps2c_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt;

    // Frame FSM
    rx_state_t      r_state, w_state_next;
    logic [2:0]     r_bit_cnt, w_bit_cnt_next;
    logic [7:0]     r_data, w_data_next;
    logic           r_parity, w_parity_next;
    logic [WDW-1:0] r_wdog;
    logic           w_timeout, w_byte_ok, w_frame_bad;

    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_wdog == WDW'(TIMEOUT_CYC - 1));

    // Frame capture state register.
    always_ff @(posedge i_sysclk) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_parity  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_data    <= w_data_next;
            r_parity  <= w_parity_next;
        end
    end

    // Next state: bits are taken on each filtered falling edge of ps2c.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_data_next    = r_data;
        w_parity_next  = r_parity;
        w_byte_ok      = 1'b0;
        w_frame_bad    = 1'b0;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_frame_bad  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !r_ps2d_sync) begin
                        w_state_next   = ST_DATA;
                        w_bit_cnt_next = '0;
                    end
                end
                ST_DATA: begin
                    if (w_fall) begin
                        w_data_next    = {r_ps2d_sync, r_data[7:1]};
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            w_state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (w_fall) begin
                        w_parity_next = r_ps2d_sync;
                        w_state_next  = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_fall) begin
                        w_state_next = ST_IDLE;
                        if (frame_ok(r_data, r_parity, r_ps2d_sync))
                            w_byte_ok = 1'b1;
                        else
                            w_frame_bad = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Watchdog: restarted by every fall, idle outside a frame.
    always_ff @(posedge i_sysclk) begin
        if (!i_reset_n)
            r_wdog <= '0;
        else if (r_state == ST_IDLE || w_fall)
            r_wdog <= '0;
        else
            r_wdog <= r_wdog + 1'b1;
    end

    // Accepted byte and error pulse registers.
    logic       r_rx_valid, r_frame_err;
    logic [7:0] r_rx_byte;

    always_ff @(posedge i_sysclk) begin
        if (!i_reset_n) begin
            r_rx_valid  <= 1'b0;
            r_rx_byte   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_byte_ok;
            r_rx_byte   <= r_data;
            r_frame_err <= w_frame_bad;
        end
    end

    // Decoder: prefixes, modifiers and translation
    logic       r_brk, r_ext, r_lshift, r_rshift, r_caps_held, r_caps_lock;
    logic       w_shift_held, w_char_key, w_push;
    logic [7:0] w_key_ascii;

    assign w_shift_held = r_lshift | r_rshift;

    ps2_key2ascii u_key2ascii (
        .i_scan_code (r_rx_byte),
        .i_upper     (w_shift_held ^ r_caps_lock),
        .i_shifted   (w_shift_held),
        .o_ascii     (w_key_ascii)
    );

    // A plain make of a non-modifier key yields a character candidate.
    always_comb begin
        w_char_key = r_rx_valid && !r_brk && !r_ext
                     && (r_rx_byte != PS2_BRK) && (r_rx_byte != PS2_EXT)
                     && (r_rx_byte != PS2_LSHIFT) && (r_rx_byte != PS2_RSHIFT)
                     && (r_rx_byte != PS2_CAPS);
        w_push = w_char_key && (w_key_ascii != ASCII_NONE);
    end

    // Prefix flags and modifier state; any non-prefix byte clears the prefixes.
    always_ff @(posedge i_sysclk) begin
        if (!i_reset_n) begin
            r_brk       <= 1'b0;
            r_ext       <= 1'b0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps_held <= 1'b0;
            r_caps_lock <= 1'b0;
        end else if (r_rx_valid) begin
            if (r_rx_byte == PS2_BRK) begin
                r_brk <= 1'b1;
            end else if (r_rx_byte == PS2_EXT) begin
                r_ext <= 1'b1;
            end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (!r_ext) begin
                    if (r_brk) begin
                        case (r_rx_byte)
                            PS2_LSHIFT: r_lshift    <= 1'b0;
                            PS2_RSHIFT: r_rshift    <= 1'b0;
                            PS2_CAPS:   r_caps_held <= 1'b0;
                            default: ;
                        endcase
                    end else begin
                        case (r_rx_byte)
                            PS2_LSHIFT: r_lshift <= 1'b1;
                            PS2_RSHIFT: r_rshift <= 1'b1;
                            PS2_CAPS: begin
                                if (!r_caps_held) begin
                                    r_caps_lock <= ~r_caps_lock;
                                    r_caps_held <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Character FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_full, w_empty, w_pop, w_wr;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = io_bus.rd_en & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = w_push & (~w_full | w_pop);

    // Storage array, no reset needed.
    always_ff @(posedge i_sysclk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_key_ascii;
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge i_sysclk) begin
        if (!i_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_push && !w_wr)
                r_overflow <= 1'b1;
        end
    end

    assign io_bus.ascii      = w_empty ? ASCII_NONE : r_mem[r_rd_ptr];
    assign io_bus.valid      = ~w_empty;
    assign io_bus.count      = r_count;
    assign io_bus.overflow   = r_overflow;
    assign io_bus.frame_err  = r_frame_err;
    assign io_bus.shift_held = w_shift_held;
    assign io_bus.caps_lock  = r_caps_lock;

endmodule

// File: tb/tb_ps2_kbd_fifo_rx.sv
// Directed and randomized checks of the PS/2 keyboard receiver with a
// key-level reference model (held keys, caps toggle, expected char queue).
`timescale 1ns/1ps
module tb_ps2_kbd_fifo_rx;

    localparam int FD   = 4;
    localparam int TO   = 3000;
    localparam int HALF = 30;
    localparam int QTR  = 15;
    localparam int GAP  = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ps2_kbd_fifo_rx_if #(.FIFO_DEPTH(FD)) bus ();

    ps2_kbd_fifo_rx #(.FIFO_DEPTH(FD), .FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .i_sysclk  (clk),
        .i_reset_n (reset_n),
        .io_bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    int last_err_cyc = 0;
    int last_fall_cyc = 0;

    // Cycle counter and frame_err pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.frame_err === 1'b1) begin
            err_pulses   = err_pulses + 1;
            last_err_cyc = cyc;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    string digit_syms = ")!@#$%^&*(";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the first nbits of a frame; optionally pulse rd_en so it lands on
    // the cycle the stop-bit byte is pushed (raw fall + 12 sysclk edges).
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits,
                             input bit rd_at_push);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2d = fr[i];
            repeat (QTR) @(negedge clk);
            bus.ps2c = 1'b0;
            last_fall_cyc = cyc;
            if (rd_at_push && i == 10) begin
                repeat (11) @(negedge clk);
                bus.rd_en = 1'b1;
                @(negedge clk);
                bus.rd_en = 1'b0;
                chk("full_rd_with_push_count", 32'(bus.count), FD);
                repeat (HALF - 12) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bus.ps2c = 1'b1;
            repeat (QTR - 1) @(negedge clk);
        end
        bus.ps2d = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11, 1'b0);
        repeat (GAP) @(negedge clk);
        $display("tx scan 0x%02h count=%0d", b, bus.count);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.valid), 1);
        chk(tag, 32'(bus.ascii), 32'(exp));
        $display("rd ascii 0x%02h", bus.ascii);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    // Reference model state
    bit m_lshift, m_rshift, m_caps;
    logic [7:0] exp_q[$];

    initial begin
        int e0, delta, sel, idx;
        logic [7:0] code, ch;
        bit sh;
        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        bus.rd_en = 1'b0;
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_valid", 32'(bus.valid), 0);
        chk("reset_ascii", 32'(bus.ascii), 0);
        chk("reset_count", 32'(bus.count), 0);
        chk("reset_flags", {28'd0, bus.overflow, bus.frame_err, bus.shift_held, bus.caps_lock}, 0);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);

        // Make and break of 'a'
        send(8'h1C); send(8'hF0); send(8'h1C);
        chk("t1_valid", 32'(bus.valid), 1);
        chk("t1_count", 32'(bus.count), 1);
        chk("t1_ascii", 32'(bus.ascii), 32'h61);
        bus.rd_en = 1'b1; @(negedge clk); bus.rd_en = 1'b0; @(negedge clk);
        chk("t1_valid_after_rd", 32'(bus.valid), 0);
        chk("t1_ascii_after_rd", 32'(bus.ascii), 0);
        chk("t1_no_frame_err", err_pulses, 0);

        // Shift
        send(8'h12);
        chk("t2_shift_on", 32'(bus.shift_held), 1);
        send(8'h1C); send(8'hF0); send(8'h1C);
        chk("t2_shift_still", 32'(bus.shift_held), 1);
        send(8'hF0); send(8'h12);
        chk("t2_shift_off", 32'(bus.shift_held), 0);
        send(8'h1C);
        chk("t2_count", 32'(bus.count), 2);
        pop_expect("t2_upper_a", 8'h41);
        pop_expect("t2_lower_a", 8'h61);

        // Caps lock
        send(8'h58); send(8'hF0); send(8'h58);
        chk("t3_caps_on", 32'(bus.caps_lock), 1);
        send(8'h1C); send(8'h16);
        pop_expect("t3_caps_a", 8'h41);
        pop_expect("t3_digit_1", 8'h31);
        send(8'h58); send(8'hF0); send(8'h58);
        chk("t3_caps_off", 32'(bus.caps_lock), 0);

        // Parity error, then timeout
        e0 = err_pulses;
        send_bits(8'h1C, 1'b1, 11, 1'b0);
        repeat (GAP) @(negedge clk);
        chk("t4_parity_err_pulses", err_pulses - e0, 1);
        chk("t4_parity_count", 32'(bus.count), 0);
        e0 = err_pulses;
        send_bits(8'h1C, 1'b0, 5, 1'b0);
        for (int k = 0; k < TO + 200 && err_pulses == e0; k++) @(negedge clk);
        delta = last_err_cyc - last_fall_cyc;
        chk("t4_timeout_err_pulses", err_pulses - e0, 1);
        chk("t4_timeout_window", 32'((delta >= TO) && (delta <= TO + 30)), 1);
        send(8'h1C);
        pop_expect("t4_after_timeout", 8'h61);

        // Overflow and full-FIFO read coincident with push
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24); send(8'h2B);
        chk("t5_count_full", 32'(bus.count), FD);
        chk("t5_overflow", 32'(bus.overflow), 1);
        pop_expect("t5_a", 8'h61);
        pop_expect("t5_b", 8'h62);
        pop_expect("t5_c", 8'h63);
        pop_expect("t5_d", 8'h64);
        chk("t5_empty", 32'(bus.count), 0);
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
        send_bits(8'h24, 1'b0, 11, 1'b1);
        repeat (GAP) @(negedge clk);
        chk("t5_count_after", 32'(bus.count), FD);
        pop_expect("t5_b2", 8'h62);
        pop_expect("t5_c2", 8'h63);
        pop_expect("t5_d2", 8'h64);
        pop_expect("t5_e2", 8'h65);

        // Reset in the middle of a frame
        send(8'h12); send(8'h1C);
        send_bits(8'h2B, 1'b0, 6, 1'b0);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        chk("t6_valid", 32'(bus.valid), 0);
        chk("t6_ascii", 32'(bus.ascii), 0);
        chk("t6_count", 32'(bus.count), 0);
        chk("t6_flags", {28'd0, bus.overflow, bus.frame_err, bus.shift_held, bus.caps_lock}, 0);
        repeat (50) @(negedge clk);
        send(8'h1C);
        pop_expect("t6_after_reset", 8'h61);

        // Randomized key actions against the key-level model
        m_lshift = 0; m_rshift = 0; m_caps = 0;
        for (int it = 0; it < 14; it++) begin
            sel = $urandom_range(0, 5);
            sh = m_lshift | m_rshift;
            if (sel <= 2) begin
                if ($urandom_range(0, 1) == 0) begin
                    idx  = $urandom_range(0, 25);
                    code = letters[idx];
                    ch   = 8'h61 + 8'(idx);
                    if (sh ^ m_caps) ch = ch - 8'h20;
                end else begin
                    idx  = $urandom_range(0, 9);
                    code = digits[idx];
                    ch   = sh ? 8'(digit_syms[idx]) : 8'h30 + 8'(idx);
                end
                send(code);
                exp_q.push_back(ch);
                if ($urandom_range(0, 1) == 1) begin
                    send(8'hF0); send(code);
                end
            end else if (sel == 3) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (m_lshift) begin send(8'hF0); send(8'h12); end else send(8'h12);
                    m_lshift = ~m_lshift;
                end else begin
                    if (m_rshift) begin send(8'hF0); send(8'h59); end else send(8'h59);
                    m_rshift = ~m_rshift;
                end
            end else if (sel == 4) begin
                send(8'h58); send(8'hF0); send(8'h58);
                m_caps = ~m_caps;
            end else begin
                send(8'hE0); send(letters[$urandom_range(0, 25)]);
            end
            chk("rnd_shift", 32'(bus.shift_held), 32'(m_lshift | m_rshift));
            chk("rnd_caps", 32'(bus.caps_lock), 32'(m_caps));
            chk("rnd_count", 32'(bus.count), exp_q.size());
            while (exp_q.size() > 0) begin
                ch = exp_q.pop_front();
                pop_expect("rnd_char", ch);
            end
        end
        chk("final_no_overflow", 32'(bus.overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
